syscall_stat_unit: RTL and testbench



---
 rtl/mips_pkg.sv | 16 +
 rtl/sat_counter.sv | 41 ++++
 rtl/syscall_stat_unit.sv | 224 ++++++++++++++++++++++
 tb/tb_syscall_stat_unit.sv | 281 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/mips_pkg.sv
// Shared definitions for the MIPS control-side helper blocks.
//
// Contents:
//   state_e            - syscall/run-control state (run, paused, halted)
//   SYSCALL_HALT_CODE  - default $v0 value that makes SYSCALL halt the core
package mips_pkg;

  typedef enum logic [1:0] {
    StRun   = 2'b00,
    StPause = 2'b01,
    StHalt  = 2'b10
  } state_e;

  localparam int unsigned SYSCALL_HALT_CODE = 10;

endpackage

// File: rtl/sat_counter.sv
// Saturating up-counter used for run statistics.
//
// Parameters:
//   CNT_W  - counter width; the count sticks at 2^CNT_W-1 instead of wrapping
// Ports:
//   clk    in  rising-edge clock
//   rst_n  in  asynchronous active-low reset, clears the count
//   inc    in  count one event this cycle
//   count  out current count (registered)
module sat_counter #(
  parameter int unsigned CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             inc,
  output logic [CNT_W-1:0] count
);

  logic [CNT_W-1:0] count_q, count_d;
  logic             at_max;

  assign at_max = &count_q;

  always_comb begin
    count_d = count_q;
    if (inc && !at_max) begin
      count_d = count_q + 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

  assign count = count_q;

endmodule

// File: rtl/syscall_stat_unit.sv
// SYSCALL side-effect executor and run-statistics block.
//
// Samples the control bits of the instruction retiring each cycle. A SYSCALL with
// $v0 == HALT_CODE halts the core until reset; any other SYSCALL latches $a0 onto
// the display outputs. Saturating counters record cycles spent running, jumps,
// conditional branches and taken branches. stall freezes PC/fetch whenever the
// unit is not in the run state.
//
// Build option:
//   SYSCALL_PAUSE_EN  when defined, a display SYSCALL also pauses the core until a
//                     rising edge of go; when undefined go is unused, the pause state
//                     is unreachable and stall equals halt.
//
// Parameters:
//   CNT_W      width of every statistics counter
//   HALT_CODE  $v0 value that makes SYSCALL halt
// Ports:
//   clk, rst_n                    clock, asynchronous active-low reset
//   instr_valid                   an instruction retires this cycle
//   IsSyscall, Jump, IsJR, Branch decoded control bits of the retiring instruction
//   branch_taken                  branch condition resolved true
//   v0, a0                        current $v0 / $a0 register values
//   go                            resume button (synchronous level)
//   stall, halt                   run-control outputs decoded from the state register
//   disp_data, disp_valid         last displayed $a0 and its one-cycle update pulse
//   cycle_cnt, jump_cnt,
//   branch_cnt, taken_cnt         saturating statistics
module syscall_stat_unit
  import mips_pkg::*;
#(
  parameter int unsigned CNT_W     = 16,
  parameter int unsigned HALT_CODE = SYSCALL_HALT_CODE
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             instr_valid,
  input  logic             IsSyscall,
  input  logic             Jump,
  input  logic             IsJR,
  input  logic             Branch,
  input  logic             branch_taken,
  input  logic [31:0]      v0,
  input  logic [31:0]      a0,
  input  logic             go,
  output logic             stall,
  output logic             halt,
  output logic [31:0]      disp_data,
  output logic             disp_valid,
  output logic [CNT_W-1:0] cycle_cnt,
  output logic [CNT_W-1:0] jump_cnt,
  output logic [CNT_W-1:0] branch_cnt,
  output logic [CNT_W-1:0] taken_cnt
);

  state_e state_q, state_d;

  logic        running;
  logic        retire;
  logic        syscall_fire;
  logic        halt_req;
  logic        display_fire;
  logic        go_rise;

  logic [31:0] disp_data_q, disp_data_d;
  logic        disp_valid_q, disp_valid_d;

  // ---------------------------------------------------------------------------
  // Retire qualification
  // ---------------------------------------------------------------------------
  // Control bits only count while running; anything presented during pause or
  // halt belongs to a frozen pipeline and is dropped.
  assign running      = (state_q == StRun);
  assign retire       = instr_valid & running;
  assign syscall_fire = retire & IsSyscall;
  assign halt_req     = (v0 == 32'(HALT_CODE));
  assign display_fire = syscall_fire & ~halt_req;

  // ---------------------------------------------------------------------------
  // Resume button edge detect (pause build only)
  // ---------------------------------------------------------------------------
`ifdef SYSCALL_PAUSE_EN
  localparam state_e DisplayNext = StPause;

  logic go_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      go_q <= 1'b0;
    end else begin
      go_q <= go;
    end
  end

  // Only acted on in the pause state, so an edge that lines up with the
  // pausing SYSCALL (still in run) is dropped.
  assign go_rise = go & ~go_q;
`else
  localparam state_e DisplayNext = StRun;

  logic unused_go;

  assign unused_go = go;
  assign go_rise   = 1'b0;
`endif

  // ---------------------------------------------------------------------------
  // Run-control FSM: state register
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= StRun;
    end else begin
      state_q <= state_d;
    end
  end

  // ---------------------------------------------------------------------------
  // Run-control FSM: next state
  // ---------------------------------------------------------------------------
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StRun: begin
        if (syscall_fire) begin
          state_d = halt_req ? StHalt : DisplayNext;
        end
      end
      StPause: begin
        if (go_rise) begin
          state_d = StRun;
        end
      end
      // Halt is left only through reset.
      StHalt:  state_d = StHalt;
      default: state_d = StRun;
    endcase
  end

  // ---------------------------------------------------------------------------
  // Run-control FSM: outputs (pure decode of the state register)
  // ---------------------------------------------------------------------------
  always_comb begin
    stall = 1'b1;
    halt  = 1'b0;
    unique case (state_q)
      StRun:   stall = 1'b0;
      StPause: stall = 1'b1;
      StHalt:  halt  = 1'b1;
      default: stall = 1'b1;
    endcase
  end

  // ---------------------------------------------------------------------------
  // Display latch
  // ---------------------------------------------------------------------------
  always_comb begin
    disp_data_d  = disp_data_q;
    disp_valid_d = display_fire;
    if (display_fire) begin
      disp_data_d = a0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      disp_data_q  <= '0;
      disp_valid_q <= 1'b0;
    end else begin
      disp_data_q  <= disp_data_d;
      disp_valid_q <= disp_valid_d;
    end
  end

  assign disp_data  = disp_data_q;
  assign disp_valid = disp_valid_q;

  // ---------------------------------------------------------------------------
  // Statistics
  // ---------------------------------------------------------------------------
  logic inc_cycle, inc_jump, inc_branch, inc_taken;

  // The SYSCALL cycle itself is a run cycle, so it is counted.
  assign inc_cycle  = running;
  assign inc_jump   = retire & (Jump | IsJR);
  assign inc_branch = retire & Branch;
  assign inc_taken  = retire & Branch & branch_taken;

  sat_counter #(
    .CNT_W (CNT_W)
  ) u_cycle_cnt (
    .clk   (clk),
    .rst_n (rst_n),
    .inc   (inc_cycle),
    .count (cycle_cnt)
  );

  sat_counter #(
    .CNT_W (CNT_W)
  ) u_jump_cnt (
    .clk   (clk),
    .rst_n (rst_n),
    .inc   (inc_jump),
    .count (jump_cnt)
  );

  sat_counter #(
    .CNT_W (CNT_W)
  ) u_branch_cnt (
    .clk   (clk),
    .rst_n (rst_n),
    .inc   (inc_branch),
    .count (branch_cnt)
  );

  sat_counter #(
    .CNT_W (CNT_W)
  ) u_taken_cnt (
    .clk   (clk),
    .rst_n (rst_n),
    .inc   (inc_taken),
    .count (taken_cnt)
  );

endmodule

// File: tb/tb_syscall_stat_unit.sv
// Directed self-checking bench for syscall_stat_unit. A second instance with
// 4-bit counters exercises saturation on the same stimulus.
module tb_syscall_stat_unit;

  logic        clk;
  logic        rst_n;
  logic        instr_valid;
  logic        IsSyscall;
  logic        Jump;
  logic        IsJR;
  logic        Branch;
  logic        branch_taken;
  logic [31:0] v0;
  logic [31:0] a0;
  logic        go;

  logic        stall, halt, disp_valid;
  logic [31:0] disp_data;
  logic [15:0] cycle_cnt, jump_cnt, branch_cnt, taken_cnt;

  logic        s_stall, s_halt, s_disp_valid;
  logic [31:0] s_disp_data;
  logic [3:0]  s_cycle_cnt, s_jump_cnt, s_branch_cnt, s_taken_cnt;

  int n_assert;
  int n_fail;
  int exp_cyc;
  bit exp_run;

  syscall_stat_unit #(
    .CNT_W     (16),
    .HALT_CODE (10)
  ) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .instr_valid  (instr_valid),
    .IsSyscall    (IsSyscall),
    .Jump         (Jump),
    .IsJR         (IsJR),
    .Branch       (Branch),
    .branch_taken (branch_taken),
    .v0           (v0),
    .a0           (a0),
    .go           (go),
    .stall        (stall),
    .halt         (halt),
    .disp_data    (disp_data),
    .disp_valid   (disp_valid),
    .cycle_cnt    (cycle_cnt),
    .jump_cnt     (jump_cnt),
    .branch_cnt   (branch_cnt),
    .taken_cnt    (taken_cnt)
  );

  syscall_stat_unit #(
    .CNT_W     (4),
    .HALT_CODE (10)
  ) dut_small (
    .clk          (clk),
    .rst_n        (rst_n),
    .instr_valid  (instr_valid),
    .IsSyscall    (IsSyscall),
    .Jump         (Jump),
    .IsJR         (IsJR),
    .Branch       (Branch),
    .branch_taken (branch_taken),
    .v0           (v0),
    .a0           (a0),
    .go           (go),
    .stall        (s_stall),
    .halt         (s_halt),
    .disp_data    (s_disp_data),
    .disp_valid   (s_disp_valid),
    .cycle_cnt    (s_cycle_cnt),
    .jump_cnt     (s_jump_cnt),
    .branch_cnt   (s_branch_cnt),
    .taken_cnt    (s_taken_cnt)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp)
    else begin
      n_fail++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // One clock edge; sample 1 ns later. exp_run describes the state during the
  // cycle that just ended, so the cycle model advances before callers update it.
  task automatic tick();
    @(posedge clk);
    #1;
    if (exp_run) exp_cyc++;
  endtask

  task automatic clear_ctl();
    instr_valid  = 1'b0;
    IsSyscall    = 1'b0;
    Jump         = 1'b0;
    IsJR         = 1'b0;
    Branch       = 1'b0;
    branch_taken = 1'b0;
  endtask

  initial begin
    n_assert = 0;
    n_fail   = 0;
    exp_cyc  = 0;
    exp_run  = 1'b1;
    rst_n    = 1'b0;
    go       = 1'b0;
    v0       = '0;
    a0       = '0;
    clear_ctl();

    // Reset state
    #2;
    chk("rst_stall", {31'b0, stall}, 32'd0);
    chk("rst_halt", {31'b0, halt}, 32'd0);
    chk("rst_disp_data", disp_data, 32'd0);
    chk("rst_disp_valid", {31'b0, disp_valid}, 32'd0);
    chk("rst_cycle", {16'b0, cycle_cnt}, 32'd0);
    chk("rst_jump", {16'b0, jump_cnt}, 32'd0);
    chk("rst_branch", {16'b0, branch_cnt}, 32'd0);
    chk("rst_taken", {16'b0, taken_cnt}, 32'd0);
    #10 rst_n = 1'b1;

    // Five idle run cycles
    repeat (5) tick();
    chk("idle_cycle", {16'b0, cycle_cnt}, 32'd5);
    chk("idle_jump", {16'b0, jump_cnt}, 32'd0);
    chk("idle_branch", {16'b0, branch_cnt}, 32'd0);
    chk("idle_taken", {16'b0, taken_cnt}, 32'd0);
    chk("idle_stall", {31'b0, stall}, 32'd0);
    chk("small_cycle5", {28'b0, s_cycle_cnt}, 32'd5);

    // Saturation of the 4-bit instance: 15 and then 20 cycles total
    repeat (10) tick();
    chk("small_cycle15", {28'b0, s_cycle_cnt}, 32'd15);
    repeat (5) tick();
    chk("small_cycle_sat", {28'b0, s_cycle_cnt}, 32'd15);
    chk("big_cycle20", {16'b0, cycle_cnt}, 32'd20);

    // BEQ taken, BNE not taken, JAL, JR
    instr_valid = 1'b1;
    Branch = 1'b1; branch_taken = 1'b1;
    tick();
    branch_taken = 1'b0;
    tick();
    Branch = 1'b0; Jump = 1'b1;
    tick();
    Jump = 1'b0; IsJR = 1'b1;
    tick();
    clear_ctl();
    chk("seq_branch", {16'b0, branch_cnt}, 32'd2);
    chk("seq_taken", {16'b0, taken_cnt}, 32'd1);
    chk("seq_jump", {16'b0, jump_cnt}, 32'd2);

    // Control bits without instr_valid are not counted
    Branch = 1'b1; branch_taken = 1'b1; Jump = 1'b1;
    tick();
    chk("novalid_branch", {16'b0, branch_cnt}, 32'd2);
    // Jump, branch and taken in the same retire
    instr_valid = 1'b1;
    tick();
    clear_ctl();
    chk("multi_jump", {16'b0, jump_cnt}, 32'd3);
    chk("multi_branch", {16'b0, branch_cnt}, 32'd3);
    chk("multi_taken", {16'b0, taken_cnt}, 32'd2);
    chk("multi_cycle", {16'b0, cycle_cnt}, exp_cyc);

    // Display SYSCALL
    v0 = 32'd1; a0 = 32'h0000_002A;
    instr_valid = 1'b1; IsSyscall = 1'b1;
    tick();
    clear_ctl();
`ifdef SYSCALL_PAUSE_EN
    exp_run = 1'b0;
`endif
    chk("disp_data", disp_data, 32'h2A);
    chk("disp_valid_hi", {31'b0, disp_valid}, 32'd1);
`ifdef SYSCALL_PAUSE_EN
    chk("disp_stall_pause", {31'b0, stall}, 32'd1);
`else
    chk("disp_stall_run", {31'b0, stall}, 32'd0);
`endif
    // Retire attempt while (possibly) paused
    instr_valid = 1'b1; Branch = 1'b1;
    tick();
    clear_ctl();
    chk("disp_valid_lo", {31'b0, disp_valid}, 32'd0);
`ifdef SYSCALL_PAUSE_EN
    chk("pause_branch_frozen", {16'b0, branch_cnt}, 32'd3);
    chk("pause_stall_hold", {31'b0, stall}, 32'd1);
    go = 1'b1;
    tick();
    exp_run = 1'b1;
    chk("resume_stall", {31'b0, stall}, 32'd0);
    go = 1'b0;
`else
    chk("run_branch_counted", {16'b0, branch_cnt}, 32'd4);
    go = 1'b1;
    tick();
    go = 1'b0;
    chk("go_ignored_stall", {31'b0, stall}, 32'd0);
`endif
    chk("disp_cycle", {16'b0, cycle_cnt}, exp_cyc);

    // Halt SYSCALL
    v0 = 32'd10; a0 = 32'h0000_0055;
    instr_valid = 1'b1; IsSyscall = 1'b1;
    tick();
    clear_ctl();
    exp_run = 1'b0;
    chk("halt_halt", {31'b0, halt}, 32'd1);
    chk("halt_stall", {31'b0, stall}, 32'd1);
    chk("halt_disp_keep", disp_data, 32'h2A);
    chk("halt_no_pulse", {31'b0, disp_valid}, 32'd0);
    instr_valid = 1'b1; Branch = 1'b1; branch_taken = 1'b1; Jump = 1'b1;
    for (int i = 0; i < 4; i++) begin
      go = ~go;
      tick();
    end
    clear_ctl();
    go = 1'b0;
    tick();
    chk("halt_cycle_frozen", {16'b0, cycle_cnt}, exp_cyc);
`ifdef SYSCALL_PAUSE_EN
    chk("halt_branch_frozen", {16'b0, branch_cnt}, 32'd3);
`else
    chk("halt_branch_frozen", {16'b0, branch_cnt}, 32'd4);
`endif
    chk("halt_jump_frozen", {16'b0, jump_cnt}, 32'd3);
    chk("halt_still", {31'b0, halt}, 32'd1);

    // Asynchronous reset out of halt, no clock edge
    #2 rst_n = 1'b0;
    #1;
    chk("arst_halt", {31'b0, halt}, 32'd0);
    chk("arst_stall", {31'b0, stall}, 32'd0);
    chk("arst_cycle", {16'b0, cycle_cnt}, 32'd0);
    chk("arst_disp", disp_data, 32'd0);
    #10 rst_n = 1'b1;
    exp_run = 1'b1;
    exp_cyc = 0;

    // Display SYSCALL with go rising in the same cycle, then reset mid-pause
    v0 = 32'd4; a0 = 32'h0000_0007;
    instr_valid = 1'b1; IsSyscall = 1'b1; go = 1'b1;
    tick();
    clear_ctl();
    tick();
    chk("disp2_data", disp_data, 32'h7);
`ifdef SYSCALL_PAUSE_EN
    chk("coincident_go_ignored", {31'b0, stall}, 32'd1);
`else
    chk("nopause_stall", {31'b0, stall}, 32'd0);
`endif
    #2 rst_n = 1'b0;
    #1;
    chk("arst2_stall", {31'b0, stall}, 32'd0);
    chk("arst2_cycle", {16'b0, cycle_cnt}, 32'd0);
    chk("arst2_jump", {16'b0, jump_cnt}, 32'd0);
    chk("arst2_disp", disp_data, 32'd0);
    chk("arst2_valid", {31'b0, disp_valid}, 32'd0);
    go = 1'b0;
    #10 rst_n = 1'b1;
    tick();
    chk("post_rst_cycle", {16'b0, cycle_cnt}, 32'd1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
